instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage directly upstream of the multi-cycle memory controller/decoder. It holds the program counter and fetches 16-bit instruction words from instruction memory over a req/ack handshake. Fetched words are buffered in a 2-entry prefetch queue and handed to the controller over a valid/ready interface, together with their PC. It also handles control-flow redirects and stops at the HALT opcode.

## Interface
- ADDR_W, 8, instruction address width; PC wraps modulo 2^ADDR_W
- DATA_W, 16, instruction word width; opcode is bits [15:12]
- RESET_PC, 0, PC value after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  level enable; fetching begins on the first clk edge with start=1 while in IDLE
- mem_req  out  1  memory read request; held until mem_ack or redirect
- mem_addr  out  ADDR_W  read address; stable while mem_req=1
- mem_ack  in  1  read data valid this cycle; only meaningful while mem_req=1
- mem_rdata  in  DATA_W  read data, sampled when mem_req & mem_ack
- redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address
- instr_valid  out  1  queue head valid
- instr_ready  in  1  controller accepts head this cycle
- instr  out  DATA_W  queue head word
- instr_pc  out  ADDR_W  address of queue head word
- fstate  out  3  current FSM state (debug, like the controller's state output)

## Operation
- States (fstate encoding): IDLE=0, REQ=1, WAIT_SPACE=2, FLUSH=3, HALTED=4.
- IDLE: mem_req=0. start=1 -> REQ.
- REQ: mem_req=1, mem_addr=pc.
  - On mem_ack: push {mem_rdata, pc} into the queue and set pc <= pc+1 (mod 2^ADDR_W).
  - If the pushed word has opcode 4'hF (HALT) -> HALTED.
  - Else if the queue count after this cycle's push/pop is 2 -> WAIT_SPACE.
  - Else stay in REQ and issue the next address.
- WAIT_SPACE: mem_req=0. Go to REQ when the count drops below 2, i.e. the cycle after a pop.
- HALTED: mem_req=0. The queue continues to drain. Only redirect or reset leaves this state.
- Redirect, taking priority over everything in any state except IDLE:
  - Queue cleared, pc <= redirect_pc, then FLUSH.
  - If mem_ack arrives in the same cycle, that data is discarded.
- FLUSH: mem_req=0 for exactly one cycle so the memory sees the old request cancelled, then REQ.
- Redirect in IDLE is ignored.
- start is ignored outside IDLE. Deasserting start does not stop fetching.
- Queue behaviour:
  - Pop when instr_valid & instr_ready.
  - Push and pop in the same cycle are allowed at any count, including full; count is unchanged.
  - Push never happens when the queue is full, because no request is issued at count 2.
- Reset mid-operation: every output returns to its reset value immediately (asynchronously). In-flight data is lost.

## Timing
- Reset values:
  - mem_req=0, mem_addr=RESET_PC
  - instr_valid=0, instr=0, instr_pc=0
  - fstate=IDLE
  - internal pc=RESET_PC, queue count=0
- start sampled high in IDLE at edge t -> mem_req=1 after edge t.
- mem_ack at edge t into an empty queue -> instr_valid=1 after edge t (1-cycle latency). The next request's address appears after the same edge.
- Back-to-back zero-wait memory with instr_ready=1 gives a sustained 1 instruction per cycle.
- Redirect at edge t -> FLUSH after t, and mem_req=1 with mem_addr=redirect_pc after t+1.
  - instr_valid=0 from after t until the first new word arrives.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package fetch_pkg holds:
  - state enum/constants (IDLE..HALTED) and the fstate width
  - HALT_OP = 4'hF
  - OPCODE_MSB/LSB slice constants, shared with the controller's decoder
- Sub-module fetch_queue:
  - 2-entry FIFO of {DATA_W + ADDR_W} bits
  - push, pop, clear, count, and head outputs
  - the same async active-low reset
- instr_fetch contains the FSM, PC, and handshake logic only.

## Test plan
- Reset asserted low mid-REQ with mem_req=1 -> all outputs go to reset values before the next edge. Release reset with start=1 -> mem_req=1, mem_addr=0x00 one cycle later.
- Zero-wait memory returning 0x1234, 0x2345, 0x3456 at addresses 0,1,2, instr_ready=1 -> instr/instr_pc stream (0x1234,0), (0x2345,1), (0x3456,2) at one per cycle.
- instr_ready=0 with memory acking immediately -> exactly 2 words queued, fstate=WAIT_SPACE, mem_req=0. A single pop -> mem_req=1 next cycle at address 2.
- redirect with redirect_pc=0x40 in the same cycle as mem_ack of 0xAAAA -> 0xAAAA never appears on instr. One FLUSH cycle with mem_req=0, then mem_addr=0x40.
- Word 0xF000 fetched at PC 0x05 -> fstate=HALTED, no further mem_req. 0xF000 is delivered with instr_pc=0x05. A later redirect to 0x10 resumes fetching.
- PC wrap: redirect_pc=0xFF with two acks -> instr_pc values 0xFF then 0x00.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its downstream decoder.
package fetch_pkg;

    localparam int unsigned FSTATE_W = 3;

    localparam logic [FSTATE_W-1:0] S_IDLE       = 3'd0;
    localparam logic [FSTATE_W-1:0] S_REQ        = 3'd1;
    localparam logic [FSTATE_W-1:0] S_WAIT_SPACE = 3'd2;
    localparam logic [FSTATE_W-1:0] S_FLUSH      = 3'd3;
    localparam logic [FSTATE_W-1:0] S_HALTED     = 3'd4;

    localparam logic [3:0]  HALT_OP    = 4'hF;
    localparam int unsigned OPCODE_MSB = 15;
    localparam int unsigned OPCODE_LSB = 12;

    function automatic logic is_halt(input logic [3:0] opcode);
        return opcode == HALT_OP;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry prefetch FIFO; entry 0 is the registered head presented downstream.
module fetch_queue #(
    parameter int unsigned E_W = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push_i,
    input  logic [E_W-1:0] push_entry_i,
    input  logic           pop_i,
    input  logic           clear_i,
    output logic [1:0]     count_o,
    output logic           head_valid_o,
    output logic [E_W-1:0] head_o
);

    logic [E_W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           do_pop, do_push;
    logic [1:0]     slot;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    // Write slot accounts for the shift caused by a simultaneous pop.
    assign slot    = cnt_q - {1'b0, do_pop};

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            e0_d  = '0;
            e1_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_pop) begin
                e0_d = e1_q;
            end
            if (do_push) begin
                if (slot == 2'd0) begin
                    e0_d = push_entry_i;
                end else begin
                    e1_d = push_entry_i;
                end
            end
            cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign count_o      = cnt_q;
    assign head_valid_o = (cnt_q != 2'd0);
    assign head_o       = e0_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, memory req/ack handshake, redirect and HALT handling.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 8,
    parameter int unsigned          DATA_W   = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [DATA_W-1:0]   instr,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic [FSTATE_W-1:0] fstate
);

    localparam int unsigned E_W = DATA_W + ADDR_W;

    logic [FSTATE_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                redirect_eff;
    logic                push, pop;
    logic [1:0]          q_count, count_after;
    logic [E_W-1:0]      q_head;

    assign mem_req      = (state_q == S_REQ);
    assign mem_addr     = pc_q;
    assign redirect_eff = redirect && (state_q != S_IDLE);
    assign push         = mem_req && mem_ack && !redirect_eff;
    assign pop          = instr_valid && instr_ready;
    assign count_after  = q_count + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_eff) begin
            pc_d    = redirect_pc;
            state_d = S_FLUSH;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_REQ;
                end
                S_REQ: begin
                    if (push) begin
                        pc_d = pc_q + ADDR_W'(1);
                        if (is_halt(mem_rdata[OPCODE_MSB:OPCODE_LSB])) begin
                            state_d = S_HALTED;
                        end else if (count_after == 2'd2) begin
                            state_d = S_WAIT_SPACE;
                        end
                    end
                end
                S_WAIT_SPACE: begin
                    if (count_after != 2'd2) state_d = S_REQ;
                end
                S_FLUSH:  state_d = S_REQ;
                S_HALTED: state_d = S_HALTED;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue #(
        .E_W (E_W)
    ) u_queue (
        .clk          (clk),
        .rst_n        (reset),
        .push_i       (push),
        .push_entry_i ({mem_rdata, pc_q}),
        .pop_i        (pop),
        .clear_i      (redirect_eff),
        .count_o      (q_count),
        .head_valid_o (instr_valid),
        .head_o       (q_head)
    );

    assign instr    = q_head[E_W-1:ADDR_W];
    assign instr_pc = q_head[ADDR_W-1:0];
    assign fstate   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, redirect, HALT, wrap, async reset.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic [2:0]  fstate;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W   (8),
        .DATA_W   (16),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .fstate      (fstate)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".mem_req"},     32'(mem_req),     32'h0);
        chk({tag, ".mem_addr"},    32'(mem_addr),    32'h00);
        chk({tag, ".instr_valid"}, 32'(instr_valid), 32'h0);
        chk({tag, ".instr"},       32'(instr),       32'h0000);
        chk({tag, ".instr_pc"},    32'(instr_pc),    32'h00);
        chk({tag, ".fstate"},      32'(fstate),      32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        #12;
        chk_reset_state("por");

        // Release reset with start high; fetching begins at the next edge.
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b1;
        step();
        chk("start.fstate",   32'(fstate),   32'd1);
        chk("start.mem_req",  32'(mem_req),  32'h1);
        chk("start.mem_addr", 32'(mem_addr), 32'h00);

        // Zero-wait streaming at one instruction per cycle.
        instr_ready = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h1234;
        step();
        chk("s0.valid", 32'(instr_valid), 32'h1);
        chk("s0.instr", 32'(instr),       32'h1234);
        chk("s0.pc",    32'(instr_pc),    32'h00);
        chk("s0.addr",  32'(mem_addr),    32'h01);
        mem_rdata = 16'h2345;
        step();
        chk("s1.instr", 32'(instr),    32'h2345);
        chk("s1.pc",    32'(instr_pc), 32'h01);
        chk("s1.addr",  32'(mem_addr), 32'h02);
        mem_rdata = 16'h3456;
        step();
        chk("s2.instr", 32'(instr),    32'h3456);
        chk("s2.pc",    32'(instr_pc), 32'h02);
        chk("s2.addr",  32'(mem_addr), 32'h03);
        mem_ack = 1'b0;
        step();
        chk("s3.valid",  32'(instr_valid), 32'h0);
        chk("s3.req",    32'(mem_req),     32'h1);
        chk("s3.fstate", 32'(fstate),      32'd1);

        // Backpressure: queue fills to 2 and requests stop.
        instr_ready = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1111;
        step();
        chk("bp0.instr", 32'(instr),    32'h1111);
        chk("bp0.pc",    32'(instr_pc), 32'h03);
        chk("bp0.addr",  32'(mem_addr), 32'h04);
        mem_rdata = 16'h2222;
        step();
        chk("bp1.fstate", 32'(fstate),  32'd2);
        chk("bp1.req",    32'(mem_req), 32'h0);
        chk("bp1.instr",  32'(instr),   32'h1111);
        mem_ack = 1'b0;
        step();
        chk("bp2.fstate", 32'(fstate),  32'd2);
        chk("bp2.req",    32'(mem_req), 32'h0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("bp3.fstate", 32'(fstate),   32'd1);
        chk("bp3.req",    32'(mem_req),  32'h1);
        chk("bp3.addr",   32'(mem_addr), 32'h05);
        chk("bp3.instr",  32'(instr),    32'h2222);
        chk("bp3.pc",     32'(instr_pc), 32'h04);

        // Redirect coinciding with an ack: the acked word is dropped.
        mem_ack = 1'b1; mem_rdata = 16'hAAAA; redirect = 1'b1; redirect_pc = 8'h40;
        step();
        redirect = 1'b0; mem_ack = 1'b0;
        chk("rd0.fstate", 32'(fstate),      32'd3);
        chk("rd0.req",    32'(mem_req),     32'h0);
        chk("rd0.valid",  32'(instr_valid), 32'h0);
        step();
        chk("rd1.fstate", 32'(fstate),      32'd1);
        chk("rd1.req",    32'(mem_req),     32'h1);
        chk("rd1.addr",   32'(mem_addr),    32'h40);
        chk("rd1.valid",  32'(instr_valid), 32'h0);
        instr_ready = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h4321;
        step();
        mem_ack = 1'b0;
        chk("rd2.instr", 32'(instr),    32'h4321);
        chk("rd2.pc",    32'(instr_pc), 32'h40);

        // HALT fetched at PC 0x05.
        redirect = 1'b1; redirect_pc = 8'h05;
        step();
        redirect = 1'b0;
        chk("h0.fstate", 32'(fstate), 32'd3);
        step();
        chk("h1.addr", 32'(mem_addr), 32'h05);
        instr_ready = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hF000;
        step();
        mem_ack = 1'b0;
        chk("h2.fstate", 32'(fstate),      32'd4);
        chk("h2.req",    32'(mem_req),     32'h0);
        chk("h2.valid",  32'(instr_valid), 32'h1);
        chk("h2.instr",  32'(instr),       32'hF000);
        chk("h2.pc",     32'(instr_pc),    32'h05);
        step();
        chk("h3.fstate", 32'(fstate),  32'd4);
        chk("h3.req",    32'(mem_req), 32'h0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("h4.valid",  32'(instr_valid), 32'h0);
        chk("h4.fstate", 32'(fstate),      32'd4);
        redirect = 1'b1; redirect_pc = 8'h10;
        step();
        redirect = 1'b0;
        chk("h5.fstate", 32'(fstate), 32'd3);
        step();
        chk("h6.req",  32'(mem_req),  32'h1);
        chk("h6.addr", 32'(mem_addr), 32'h10);

        // PC wrap from 0xFF to 0x00.
        redirect = 1'b1; redirect_pc = 8'hFF;
        step();
        redirect = 1'b0;
        step();
        chk("w0.addr", 32'(mem_addr), 32'hFF);
        mem_ack = 1'b1; mem_rdata = 16'h0ABC;
        step();
        chk("w1.instr", 32'(instr),    32'h0ABC);
        chk("w1.pc",    32'(instr_pc), 32'hFF);
        chk("w1.addr",  32'(mem_addr), 32'h00);
        mem_rdata = 16'h0DEF; instr_ready = 1'b1;
        step();
        chk("w2.instr", 32'(instr),    32'h0DEF);
        chk("w2.pc",    32'(instr_pc), 32'h00);
        chk("w2.addr",  32'(mem_addr), 32'h01);
        mem_ack = 1'b0; instr_ready = 1'b0;
        step();
        chk("w3.valid", 32'(instr_valid), 32'h1);
        chk("w3.req",   32'(mem_req),     32'h1);

        // Asynchronous reset mid-REQ with a queued word.
        reset = 1'b0;
        #1;
        chk_reset_state("arst");
        step();
        chk_reset_state("arst_hold");
        reset = 1'b1; start = 1'b1;
        step();
        chk("arst_rel.req",  32'(mem_req),  32'h1);
        chk("arst_rel.addr", 32'(mem_addr), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
